// File: rtl/out_uart_tx_pkg.sv
// Shared definitions for the output-register UART transmitter:
// FSM state encoding and default bit timing.
package out_uart_tx_pkg;

    localparam int unsigned OUT_UART_CLKS_PER_BIT = 16;

    typedef logic [1:0] uart_state_t;

    localparam uart_state_t ST_IDLE  = 2'd0;
    localparam uart_state_t ST_START = 2'd1;
    localparam uart_state_t ST_DATA  = 2'd2;
    localparam uart_state_t ST_STOP  = 2'd3;

endpackage

// File: rtl/out_fifo.sv
// Word FIFO between the output register and the UART. A push while full is
// ignored; fullness is judged on the current count, before any same-cycle pop.
module out_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally in AW bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/out_uart_tx.sv
// Sends each 16-bit output word as two 8N1 UART bytes, high byte first,
// with a FIFO absorbing words that arrive while a frame is in flight.
module out_uart_tx
    import out_uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = OUT_UART_CLKS_PER_BIT,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] out_data,
    input  logic        out_valid,
    output logic        txd,
    output logic        busy,
    output logic        fifo_full,
    output logic        overflow
);

    localparam logic [7:0] BIT_RELOAD = 8'(CLKS_PER_BIT - 1);

    uart_state_t state;
    logic [7:0]  cnt;
    logic [2:0]  bit_idx;
    logic        hi_lo;
    logic [15:0] hold;
    logic [7:0]  shifter;
    logic        txd_q;
    logic        overflow_q;
    logic        fifo_empty;
    logic        fifo_pop;
    logic [15:0] fifo_rd;

    assign fifo_pop = (state == ST_IDLE) && !fifo_empty;

    out_fifo #(
        .WIDTH(16),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (out_valid),
        .pop    (fifo_pop),
        .wr_data(out_data),
        .rd_data(fifo_rd),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign txd      = txd_q;
    assign overflow = overflow_q;
    assign busy     = (state != ST_IDLE) || !fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (out_valid && fifo_full) begin
            overflow_q <= 1'b1;
        end
    end

    // txd is loaded one edge ahead of each bit, so every transition below
    // sets the level the line carries for the whole of the next bit period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            hi_lo   <= 1'b0;
            hold    <= '0;
            shifter <= '0;
            txd_q   <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        hold    <= fifo_rd;
                        shifter <= fifo_rd[15:8];
                        hi_lo   <= 1'b0;
                        cnt     <= BIT_RELOAD;
                        txd_q   <= 1'b0;
                        state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (cnt == '0) begin
                        cnt     <= BIT_RELOAD;
                        bit_idx <= '0;
                        txd_q   <= shifter[0];
                        shifter <= {1'b0, shifter[7:1]};
                        state   <= ST_DATA;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_DATA: begin
                    if (cnt == '0) begin
                        cnt <= BIT_RELOAD;
                        if (bit_idx == 3'd7) begin
                            txd_q <= 1'b1;
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            txd_q   <= shifter[0];
                            shifter <= {1'b0, shifter[7:1]};
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_STOP: begin
                    if (cnt == '0) begin
                        if (!hi_lo) begin
                            hi_lo   <= 1'b1;
                            shifter <= hold[7:0];
                            cnt     <= BIT_RELOAD;
                            txd_q   <= 1'b0;
                            state   <= ST_START;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: begin
                    txd_q <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
